mem_rr_arbiter: RTL and testbench
=================================

Name: mem_rr_arbiter

Overview:
- Round-robin arbiter that shares one single-port `memory` instance (valid/ready, `wr_rd` interface) between NUM_REQ requesters.
- Sits between requester engines (DMA, CPU-side port, test sequencers) and the memory.
- Latches one request at a time, drives it to the memory, waits for `ready`, and returns read data/completion to the winning requester.
- A watchdog counter terminates stalled transfers with an error flag.

Parameters:
- WIDTH, 16, data width in bits; matches the memory.
- DEPTH, 64, memory depth in words.
- ADDR_WIDTH, $clog2(DEPTH), address width.
- NUM_REQ, 2, number of requesters; legal range 2..8.
- TIMEOUT, 255, cycles allowed in BUSY before abort; must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request.
- req_wr_rd  in  NUM_REQ  per-requester direction; 1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i uses slice i.
- req_wdata  in  NUM_REQ*WIDTH  packed write data.
- req_ready  out  NUM_REQ  one-hot, one-cycle completion pulse.
- req_rdata  out  WIDTH  read data, valid while `req_ready` is high; shared by all requesters.
- req_err  out  1  high with `req_ready` when the transfer timed out.
- grant  out  NUM_REQ  one-hot owner of the current transfer; 0 when idle.
- valid  out  1  memory request.
- wr_rd  out  1  memory direction.
- addr  out  ADDR_WIDTH  memory address.
- wdata  out  WIDTH  memory write data.
- rdata  in  WIDTH  memory read data.
- ready  in  1  memory completion.

Behaviour:

Reset (rst=0, asynchronous):
- FSM goes to IDLE; `rr_ptr`=0; timeout counter=0.
- All outputs go to 0: `valid`, `wr_rd`, `addr`, `wdata`, `grant`, `req_ready`, `req_rdata`, `req_err`.
- Reset mid-transfer drops `valid` immediately. No completion pulse is issued for the aborted transfer.

FSM states: IDLE, BUSY, RESP.

- IDLE:
  - If any `req_valid` is high, select the first asserted index searching upward from `rr_ptr` with wrap (`rr_ptr`, `rr_ptr`+1, …, NUM_REQ-1, 0, …).
  - At that edge: register `grant`, `wr_rd`, `addr` and `wdata` from the winner's slices; set `valid`=1; clear the counter; go to BUSY.
  - With no request, stay in IDLE with all outputs at 0.
- BUSY:
  - `valid`=1. `wr_rd`, `addr` and `wdata` stay stable; later requester changes are ignored.
  - Counter increments each cycle.
  - If `ready`=1 at an edge: capture `rdata` into `req_rdata` (reads only; writes hold the previous value), `req_err`=0, drop `valid`, go to RESP.
  - Else if counter==TIMEOUT-1: drop `valid`, `req_err`=1, go to RESP.
  - `ready` takes priority over timeout when both occur at the same edge.
- RESP (exactly one cycle):
  - `req_ready[g]`=1 for the granted index g. `req_rdata` and `req_err` are valid.
  - At the edge leaving RESP: `rr_ptr`=(g+1) mod NUM_REQ, `grant`=0, `req_ready`=0, `req_err`=0, go to IDLE.
- Requester rule: hold `req_valid` and its fields stable until `req_ready[i]` is seen; deassert or start a new request on the following cycle. IDLE is always entered for at least one cycle between transfers, so a requester is never double-issued.

Timing:
- Latency from `req_valid` sampled to `valid` high: 1 cycle.
- From the `ready` edge to `req_ready`: 1 cycle.
- Minimum transfer period: 3 cycles (IDLE → BUSY → RESP) when the memory answers `ready` in the first BUSY cycle.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1. Worst-case wait is (NUM_REQ-1) transfers.
- `ready` outside BUSY is ignored.

Decomposition:
- Package `mem_arb_pkg`:
  - state enum {IDLE, BUSY, RESP};
  - default WIDTH, DEPTH, TIMEOUT constants;
  - constants WR=1'b1 and RD=1'b0.
- Sub-module `rr_pick`: combinational rotate-priority picker. Inputs: request vector and pointer. Outputs: one-hot grant and winner index. Reused by other shared-resource arbiters.

Test Plan (WIDTH=16, DEPTH=64, NUM_REQ=2, arbiter connected to the `memory` model):
1. Single write then read: req0 writes addr=5, wdata=16'hA5A5, then reads addr=5 → `grant`=01 during the transfer, one `req_ready`[0] pulse per transfer, `req_rdata`=16'hA5A5, `req_err`=0.
2. Simultaneous requests after reset: req0 and req1 both request continuously, 4 transfers each to addr 0..3 → grant sequence 01,10,01,10,…; each requester is serviced 4 times; no consecutive double grant.
3. Full sweep: req1 writes all 64 addresses with $random data, then req0 reads all 64 → every read matches the scoreboard; address 63 wraps correctly to a new request at 0.
4. Timeout: memory model holds `ready`=0, TIMEOUT=8 → `valid` high exactly 8 cycles, then a `req_ready` pulse with `req_err`=1; `rr_ptr` advances and the next request proceeds normally.
5. Reset mid-transfer: assert rst low while in BUSY with `valid`=1 → `valid`, `grant` and `req_ready` go to 0 asynchronously, before the next clock edge; after release, a fresh req1 read of addr=10 completes correctly.
6. Stability: requester changes `req_addr` and `req_wdata` while BUSY → `addr` and `wdata` stay at the latched values; the memory sees the original transaction.

Source files
------------

// File: rtl/mem_rr_arbiter_pkg.sv
// Shared types and defaults for the round-robin memory arbiter.
// States, default sizing constants and direction encodings live here.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_DEPTH   = 64;
    localparam int DEF_TIMEOUT = 255;

    localparam logic WR = 1'b1;
    localparam logic RD = 1'b0;

endpackage

// File: rtl/mem_rr_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first asserted request at or above
// the pointer, wrapping around; reusable by any shared-resource arbiter.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    // Walk the requesters starting at ptr; the first hit wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any && req[IDX_W'((int'(ptr) + i) % NUM_REQ)]) begin
                any = 1'b1;
                gnt[IDX_W'((int'(ptr) + i) % NUM_REQ)] = 1'b1;
                idx = IDX_W'((int'(ptr) + i) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready single-port memory among
// NUM_REQ requesters, with a watchdog that aborts stalled transfers.
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int NUM_REQ    = 2,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_wr_rd,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]      req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [WIDTH-1:0]              req_rdata,
    output logic                          req_err,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          valid,
    output logic                          wr_rd,
    output logic [ADDR_WIDTH-1:0]         addr,
    output logic [WIDTH-1:0]              wdata,
    input  logic [WIDTH-1:0]              rdata,
    input  logic                          ready
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t state, state_nxt;

    logic [IDX_W-1:0]      rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0]      gidx, gidx_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [NUM_REQ-1:0]    grant_nxt, req_ready_nxt;
    logic [WIDTH-1:0]      req_rdata_nxt, wdata_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic                  req_err_nxt, valid_nxt, wr_rd_nxt;

    logic [NUM_REQ-1:0]    pick_gnt;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_any;

    rr_pick #(
        .NUM_REQ(NUM_REQ),
        .IDX_W  (IDX_W)
    ) u_pick (
        .req(req_valid),
        .ptr(rr_ptr),
        .gnt(pick_gnt),
        .idx(pick_idx),
        .any(pick_any)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            gidx      <= '0;
            cnt       <= '0;
            grant     <= '0;
            req_ready <= '0;
            req_rdata <= '0;
            req_err   <= 1'b0;
            valid     <= 1'b0;
            wr_rd     <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_ptr_nxt;
            gidx      <= gidx_nxt;
            cnt       <= cnt_nxt;
            grant     <= grant_nxt;
            req_ready <= req_ready_nxt;
            req_rdata <= req_rdata_nxt;
            req_err   <= req_err_nxt;
            valid     <= valid_nxt;
            wr_rd     <= wr_rd_nxt;
            addr      <= addr_nxt;
            wdata     <= wdata_nxt;
        end
    end

    // All memory-facing fields are frozen once latched, so requester churn
    // during BUSY never reaches the memory.
    always_comb begin
        state_nxt     = state;
        rr_ptr_nxt    = rr_ptr;
        gidx_nxt      = gidx;
        cnt_nxt       = cnt;
        grant_nxt     = grant;
        req_ready_nxt = req_ready;
        req_rdata_nxt = req_rdata;
        req_err_nxt   = req_err;
        valid_nxt     = valid;
        wr_rd_nxt     = wr_rd;
        addr_nxt      = addr;
        wdata_nxt     = wdata;

        case (state)
            IDLE: begin
                if (pick_any) begin
                    grant_nxt = pick_gnt;
                    gidx_nxt  = pick_idx;
                    wr_rd_nxt = req_wr_rd[pick_idx];
                    addr_nxt  = req_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_nxt = req_wdata[pick_idx*WIDTH +: WIDTH];
                    valid_nxt = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = BUSY;
                end
            end

            BUSY: begin
                if (ready) begin
                    if (wr_rd == RD) begin
                        req_rdata_nxt = rdata;
                    end
                    req_err_nxt   = 1'b0;
                    req_ready_nxt = grant;
                    valid_nxt     = 1'b0;
                    wr_rd_nxt     = 1'b0;
                    addr_nxt      = '0;
                    wdata_nxt     = '0;
                    state_nxt     = RESP;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    req_err_nxt   = 1'b1;
                    req_ready_nxt = grant;
                    valid_nxt     = 1'b0;
                    wr_rd_nxt     = 1'b0;
                    addr_nxt      = '0;
                    wdata_nxt     = '0;
                    state_nxt     = RESP;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            RESP: begin
                rr_ptr_nxt    = (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + IDX_W'(1);
                grant_nxt     = '0;
                req_ready_nxt = '0;
                req_err_nxt   = 1'b0;
                state_nxt     = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter with a small behavioural memory that
// can be stalled to exercise the watchdog.
module tb_mem_rr_arbiter;

    localparam int WIDTH   = 16;
    localparam int DEPTH   = 64;
    localparam int AW      = 6;
    localparam int NUM_REQ = 2;
    localparam int TIMEOUT = 8;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ-1:0]        req_wr_rd = '0;
    logic [NUM_REQ*AW-1:0]     req_addr  = '0;
    logic [NUM_REQ*WIDTH-1:0]  req_wdata = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic [WIDTH-1:0]          req_rdata;
    logic                      req_err;
    logic [NUM_REQ-1:0]        grant;
    logic                      valid;
    logic                      wr_rd;
    logic [AW-1:0]             addr;
    logic [WIDTH-1:0]          wdata;
    logic [WIDTH-1:0]          rdata = '0;
    logic                      ready;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] sb  [DEPTH];
    logic             stall = 1'b0;

    int pass_cnt  = 0;
    int total_cnt = 0;

    mem_rr_arbiter #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(AW),
        .NUM_REQ   (NUM_REQ),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_wr_rd(req_wr_rd),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_ready(req_ready),
        .req_rdata(req_rdata),
        .req_err  (req_err),
        .grant    (grant),
        .valid    (valid),
        .wr_rd    (wr_rd),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .ready    (ready)
    );

    always #5 clk = ~clk;

    // Memory answers one cycle after seeing valid unless stalled.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready <= 1'b0;
        end else if (valid && !ready && !stall) begin
            ready <= 1'b1;
            if (wr_rd) mem[addr] <= wdata;
            else       rdata     <= mem[addr];
        end else begin
            ready <= 1'b0;
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst       = 1'b0;
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_xfer(input int i, input logic wr, input logic [AW-1:0] a,
                            input logic [WIDTH-1:0] d, output logic done,
                            output logic [WIDTH-1:0] rd, output logic err,
                            output logic [NUM_REQ-1:0] gseen, output int busy);
        @(negedge clk);
        req_valid[i]               = 1'b1;
        req_wr_rd[i]               = wr;
        req_addr[i*AW +: AW]       = a;
        req_wdata[i*WIDTH +: WIDTH] = d;
        done  = 1'b0;
        rd    = '0;
        err   = 1'b0;
        gseen = '0;
        busy  = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (valid) busy++;
            if (grant != '0) gseen = grant;
            if (req_ready[i]) begin
                done = 1'b1;
                rd   = req_rdata;
                err  = req_err;
            end
        end
        req_valid[i] = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total_cnt++; if (valid !== 1'b0) $display("[TB] FAIL reset_valid got=%b want=0", valid); else pass_cnt++;
        total_cnt++; if (grant !== 2'b00) $display("[TB] FAIL reset_grant got=%b want=00", grant); else pass_cnt++;
        total_cnt++; if (req_ready !== 2'b00) $display("[TB] FAIL reset_req_ready got=%b want=00", req_ready); else pass_cnt++;
        total_cnt++; if (req_err !== 1'b0) $display("[TB] FAIL reset_req_err got=%b want=0", req_err); else pass_cnt++;
        total_cnt++; if (addr !== 6'd0 || wdata !== 16'd0 || wr_rd !== 1'b0) $display("[TB] FAIL reset_mem_bus got=%h/%h/%b want=0/0/0", addr, wdata, wr_rd); else pass_cnt++;
        total_cnt++; if (req_rdata !== 16'd0) $display("[TB] FAIL reset_req_rdata got=%h want=0000", req_rdata); else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_write_read();
        logic done, err;
        logic [WIDTH-1:0] rd;
        logic [NUM_REQ-1:0] gs;
        int busy;
        run_xfer(0, 1'b1, 6'd5, 16'hA5A5, done, rd, err, gs, busy);
        total_cnt++; if (!done || err !== 1'b0) $display("[TB] FAIL single_write_done got=%b/%b want=1/0", done, err); else pass_cnt++;
        total_cnt++; if (gs !== 2'b01) $display("[TB] FAIL single_write_grant got=%b want=01", gs); else pass_cnt++;
        total_cnt++; if (busy != 2) $display("[TB] FAIL single_write_busy got=%0d want=2", busy); else pass_cnt++;
        sb[5] = 16'hA5A5;
        run_xfer(0, 1'b0, 6'd5, 16'h0000, done, rd, err, gs, busy);
        total_cnt++; if (!done || err !== 1'b0) $display("[TB] FAIL single_read_done got=%b/%b want=1/0", done, err); else pass_cnt++;
        total_cnt++; if (rd !== 16'hA5A5) $display("[TB] FAIL single_read_data got=%h want=a5a5", rd); else pass_cnt++;
        total_cnt++; if (gs !== 2'b01) $display("[TB] FAIL single_read_grant got=%b want=01", gs); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (req_ready !== 2'b00 || grant !== 2'b00) $display("[TB] FAIL single_pulse_width got=%b/%b want=00/00", req_ready, grant); else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        int cnt0, cnt1, nseq;
        logic [NUM_REQ-1:0] seq [16];
        logic [NUM_REQ-1:0] prev_g;
        apply_reset();
        cnt0 = 0; cnt1 = 0; nseq = 0; prev_g = '0;
        req_wr_rd = 2'b11;
        req_addr  = '0;
        req_wdata = {16'h2000, 16'h1000};
        req_valid = 2'b11;
        for (int k = 0; k < 200 && (cnt0 < 4 || cnt1 < 4); k++) begin
            @(negedge clk);
            if (grant != '0 && prev_g == '0 && nseq < 16) begin
                seq[nseq] = grant;
                nseq++;
            end
            prev_g = grant;
            if (req_ready[0]) begin
                sb[cnt0] = 16'h1000 | 16'(cnt0);
                cnt0++;
                if (cnt0 < 4) begin
                    req_addr[0 +: AW]     = AW'(cnt0);
                    req_wdata[0 +: WIDTH] = 16'h1000 | 16'(cnt0);
                end else req_valid[0] = 1'b0;
            end
            if (req_ready[1]) begin
                sb[cnt1] = 16'h2000 | 16'(cnt1);
                cnt1++;
                if (cnt1 < 4) begin
                    req_addr[AW +: AW]        = AW'(cnt1);
                    req_wdata[WIDTH +: WIDTH] = 16'h2000 | 16'(cnt1);
                end else req_valid[1] = 1'b0;
            end
        end
        req_valid = '0;
        total_cnt++; if (cnt0 != 4) $display("[TB] FAIL simul_count0 got=%0d want=4", cnt0); else pass_cnt++;
        total_cnt++; if (cnt1 != 4) $display("[TB] FAIL simul_count1 got=%0d want=4", cnt1); else pass_cnt++;
        total_cnt++; if (nseq != 8) $display("[TB] FAIL simul_nseq got=%0d want=8", nseq); else pass_cnt++;
        for (int k = 0; k < 8 && k < nseq; k++) begin
            total_cnt++;
            if (seq[k] !== ((k % 2 == 0) ? 2'b01 : 2'b10))
                $display("[TB] FAIL simul_seq[%0d] got=%b want=%b", k, seq[k], (k % 2 == 0) ? 2'b01 : 2'b10);
            else pass_cnt++;
        end
    endtask

    task automatic test_full_sweep();
        logic done, err;
        logic [WIDTH-1:0] rd, d;
        logic [NUM_REQ-1:0] gs;
        int busy;
        for (int a = 0; a < DEPTH; a++) begin
            d = 16'($urandom);
            run_xfer(1, 1'b1, AW'(a), d, done, rd, err, gs, busy);
            sb[a] = d;
            total_cnt++;
            if (!done || err !== 1'b0 || gs !== 2'b10) $display("[TB] FAIL sweep_write[%0d] got=%b/%b/%b want=1/0/10", a, done, err, gs);
            else pass_cnt++;
        end
        for (int a = 0; a < DEPTH; a++) begin
            run_xfer(0, 1'b0, AW'(a), 16'h0000, done, rd, err, gs, busy);
            total_cnt++;
            if (!done || err !== 1'b0 || rd !== sb[a]) $display("[TB] FAIL sweep_read[%0d] got=%b/%b/%h want=1/0/%h", a, done, err, rd, sb[a]);
            else pass_cnt++;
        end
    endtask

    task automatic test_timeout();
        logic done, err, got;
        logic [WIDTH-1:0] rd;
        logic [NUM_REQ-1:0] gs;
        int busy;
        stall = 1'b1;
        run_xfer(0, 1'b0, 6'd1, 16'h0000, done, rd, err, gs, busy);
        stall = 1'b0;
        total_cnt++; if (!done) $display("[TB] FAIL timeout_done got=%b want=1", done); else pass_cnt++;
        total_cnt++; if (err !== 1'b1) $display("[TB] FAIL timeout_err got=%b want=1", err); else pass_cnt++;
        total_cnt++; if (busy != TIMEOUT) $display("[TB] FAIL timeout_valid_cycles got=%0d want=%0d", busy, TIMEOUT); else pass_cnt++;
        // rr_ptr now points at requester 1, so it wins a simultaneous request.
        req_wr_rd = 2'b00;
        req_addr  = {6'd2, 6'd3};
        req_valid = 2'b11;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (grant != '0) got = 1'b1;
        end
        total_cnt++; if (grant !== 2'b10) $display("[TB] FAIL timeout_next_grant got=%b want=10", grant); else pass_cnt++;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (req_ready[1]) got = 1'b1;
        end
        total_cnt++;
        if (!got || req_err !== 1'b0 || req_rdata !== sb[2]) $display("[TB] FAIL timeout_next_read got=%b/%b/%h want=1/0/%h", got, req_err, req_rdata, sb[2]);
        else pass_cnt++;
        req_valid[1] = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (req_ready[0]) got = 1'b1;
        end
        total_cnt++;
        if (!got || req_err !== 1'b0 || req_rdata !== sb[3]) $display("[TB] FAIL timeout_req0_read got=%b/%b/%h want=1/0/%h", got, req_err, req_rdata, sb[3]);
        else pass_cnt++;
        req_valid[0] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_transfer();
        logic done, err;
        logic [WIDTH-1:0] rd;
        logic [NUM_REQ-1:0] gs;
        int busy;
        stall = 1'b1;
        @(negedge clk);
        req_valid[0]          = 1'b1;
        req_wr_rd[0]          = 1'b1;
        req_addr[0 +: AW]     = 6'd20;
        req_wdata[0 +: WIDTH] = 16'hDEAD;
        @(posedge clk);
        #2;
        total_cnt++; if (valid !== 1'b1) $display("[TB] FAIL midrst_busy_valid got=%b want=1", valid); else pass_cnt++;
        #1 rst = 1'b0;
        #1;
        total_cnt++; if (valid !== 1'b0) $display("[TB] FAIL midrst_valid got=%b want=0", valid); else pass_cnt++;
        total_cnt++; if (grant !== 2'b00 || req_ready !== 2'b00) $display("[TB] FAIL midrst_grant_ready got=%b/%b want=00/00", grant, req_ready); else pass_cnt++;
        req_valid = '0;
        @(negedge clk);
        rst   = 1'b1;
        stall = 1'b0;
        run_xfer(1, 1'b0, 6'd10, 16'h0000, done, rd, err, gs, busy);
        total_cnt++;
        if (!done || err !== 1'b0 || rd !== sb[10] || gs !== 2'b10) $display("[TB] FAIL midrst_fresh_read got=%b/%b/%h/%b want=1/0/%h/10", done, err, rd, gs, sb[10]);
        else pass_cnt++;
    endtask

    task automatic test_stability();
        logic got;
        stall = 1'b1;
        @(negedge clk);
        req_valid[0]          = 1'b1;
        req_wr_rd[0]          = 1'b1;
        req_addr[0 +: AW]     = 6'd30;
        req_wdata[0 +: WIDTH] = 16'h1234;
        @(negedge clk);
        req_addr[0 +: AW]     = 6'd31;
        req_wdata[0 +: WIDTH] = 16'hBEEF;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total_cnt++;
            if (valid !== 1'b1 || addr !== 6'd30 || wdata !== 16'h1234) $display("[TB] FAIL stable_bus[%0d] got=%b/%h/%h want=1/1e/1234", k, valid, addr, wdata);
            else pass_cnt++;
        end
        stall = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (req_ready[0]) got = 1'b1;
        end
        req_valid[0] = 1'b0;
        total_cnt++; if (!got || req_err !== 1'b0) $display("[TB] FAIL stable_done got=%b/%b want=1/0", got, req_err); else pass_cnt++;
        sb[30] = 16'h1234;
        total_cnt++; if (mem[30] !== 16'h1234) $display("[TB] FAIL stable_mem30 got=%h want=1234", mem[30]); else pass_cnt++;
        total_cnt++; if (mem[31] !== sb[31]) $display("[TB] FAIL stable_mem31 got=%h want=%h", mem[31], sb[31]); else pass_cnt++;
        @(negedge clk);
    endtask

    initial begin
        for (int a = 0; a < DEPTH; a++) begin
            mem[a] = '0;
            sb[a]  = '0;
        end
        test_reset();
        test_single_write_read();
        test_simultaneous();
        test_full_sweep();
        test_timeout();
        test_reset_mid_transfer();
        test_stability();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
